fc_argmax: RTL



---
 rtl/fc_argmax.sv | 107 ++++++++++
 1 files changed

// File: rtl/fc_argmax.sv
// Argmax stage behind the FC layer: captures packed class scores, scans them serially,
// and presents the winning class on a valid/ready handshake. Define FC_ARGMAX_SIGNED_EN for signed scores.
module fc_argmax #(
  parameter int NUM_CLASSES = 4,
  parameter int SCORE_W     = 8,
  parameter int IDX_W       = 2,
  parameter int DROP_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [IDX_W-1:0]               out_class,
  output logic [SCORE_W-1:0]             out_score,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DROP_W-1:0]              drop_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [1:0]         state;
  logic [SCORE_W-1:0] scores [NUM_CLASSES];
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] cur;
  logic               better;

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    cur = scores[idx];
`ifdef FC_ARGMAX_SIGNED_EN
    better = $signed(cur) > $signed(best);
`else
    better = cur > best;
`endif
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      best       <= '0;
      best_idx   <= '0;
      out_class  <= '0;
      out_score  <= '0;
      out_valid  <= 1'b0;
      drop_count <= '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        scores[k] <= '0;
      end
    end else begin
      if (in_valid && (state != IDLE) && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              scores[k] <= in_scores[(NUM_CLASSES-1-k)*SCORE_W +: SCORE_W];
            end
            // Class 0 seeds the running best, so the scan pointer starts at class 1.
            best     <= in_scores[NUM_CLASSES*SCORE_W-1 -: SCORE_W];
            best_idx <= '0;
            idx      <= IDX_W'(1);
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (better) begin
            best     <= cur;
            best_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            out_class <= better ? idx : best_idx;
            out_score <= better ? cur : best;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= OUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
